tx_port_arbiter: RTL and testbench
==================================

TX_PORT_ARBITER -- requirements
Module: tx_port_arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of PHY-TX FIFOs arbitrated.
REQ-002 Parameter DWIDTH, default 8: byte-lane width of the FIFO write data.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive requester-0 grants allowed while requester 1 waits.
REQ-004 clk  in  1  system clock (100 MHz); the block SHALL use this one clock.
REQ-005 arst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_0 / req_1  in  PORTS  per-port ownership request; requester 0 is SOC, requester 1 is SWITCH.
REQ-007 val_0 / val_1  out  PORTS  per-port grant, registered.
REQ-008 din_0 / din_1  in  DWIDTH  write data, common to all ports of that requester.
REQ-009 del_0 / del_1  in  1  end-of-data marker accompanying a write, common to all ports.
REQ-010 we_0 / we_1  in  PORTS  per-port write enable.
REQ-011 fifo_din  out  PORTS*DWIDTH  muxed data; port p uses slice [p*DWIDTH +: DWIDTH].
REQ-012 fifo_we / fifo_del  out  PORTS  muxed write enable and EOD.
REQ-013 err_0 / err_1  out  PORTS  sticky flag: requester released a port mid-frame.

Function
REQ-014 Each port SHALL run an independent FSM with states IDLE, OWN0 and OWN1.
REQ-015 IDLE, req_1 low or starve count below STARVE_LIMIT, req_0 high -> OWN0 on the next edge.
REQ-016 IDLE, req_1 high, and either req_0 low or starve count equal to STARVE_LIMIT -> OWN1.
REQ-017 IDLE with no request SHALL stay in IDLE.
REQ-018 val_x[p] SHALL be high exactly while port p is in OWNx; grant latency from req to val is 1 cycle.
REQ-019 OWNx SHALL be held while req_x[p] is high; there is no preemption, including of OWN1 by req_0.
REQ-020 OWNx with req_x[p] low -> IDLE; every ownership change SHALL pass through at least one IDLE cycle.
REQ-021 Starve counter per port (width clog2(STARVE_LIMIT+1)):
  - increments, saturating, on each IDLE->OWN0 transition taken while req_1[p] is high;
  - clears on IDLE->OWN1.
REQ-022 Output mux, combinational from the registered state:
  - in OWNx: fifo_din slice = din_x, fifo_we[p] = we_x[p], fifo_del[p] = del_x & we_x[p];
  - in IDLE: fifo_we[p] = 0 and fifo_del[p] = 0, and fifo_din is don't-care (drive 0).
REQ-023 A write from a non-owner SHALL be ignored, with no side effect.
REQ-024 Frame-open flag per port:
  - set on an owner write with del = 0;
  - cleared on an owner write with del = 1.
REQ-025 Leaving OWNx with the frame-open flag set SHALL set err_x[p] and clear the frame-open flag.
REQ-026 err_x SHALL clear only on reset.
REQ-027 If release (req low) and an EOD write coincide in the same cycle, the write SHALL pass through and no error is flagged.
REQ-028 fifo_we SHALL NOT be gated by FIFO afull; the requester checks afull itself.
REQ-029 Ports SHALL NOT interact; simultaneous grants on different ports to different requesters are legal.

Reset
REQ-030 On arst_n low, immediately:
  - all FSMs go to IDLE;
  - val_0, val_1, err_0, err_1, fifo_we and fifo_del go to 0, and fifo_din to 0;
  - starve counters and frame-open flags are cleared.
REQ-031 Reset asserted mid-frame SHALL drop grants without flagging errors.
REQ-032 The first grant is possible on the second rising edge after arst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the PORTS/DWIDTH defaults.
REQ-034 Per-port logic SHALL be a sub-module tx_port_arb_cell, instantiated PORTS times in a generate loop.
REQ-035 The top level SHALL contain only the generate loop and bus slicing.

Verification
REQ-036 Scenario: req_0[0]=1 and req_1[0]=1 in the same cycle from reset, starve=0 -> val_0[0]=1 at +1 cycle and val_1[0] stays 0.
REQ-037 Scenario: req_0[2] pulsed 4 times with req_1[2] held high (STARVE_LIMIT=4) -> 5th arbitration grants val_1[2] despite req_0[2]=1; counter then 0.
REQ-038 Scenario: OWN1 on port 1, SWITCH writes 0x55,0xAA then 0x0F with del=1 -> fifo_din slice 1 shows the same bytes and fifo_del[1] pulses with 0x0F; SOC writes on we_0[1] produce no fifo_we.
REQ-039 Scenario: OWN0 on port 3, two bytes written without EOD, then req_0[3] dropped -> err_0[3]=1 next cycle and stays 1; port returns to IDLE.
REQ-040 Scenario: port 0 OWN0 and port 2 OWN1 concurrently, each writing to its port -> both streams appear on their slices, no crosstalk.
REQ-041 Scenario: arst_n pulsed low mid-frame while OWN1 -> all val/fifo_we go 0 asynchronously, err remains 0, and val_1 re-grants 2 edges after release.

Source files
------------

// File: rtl/tx_port_arbiter_pkg.sv
// Shared definitions for the PHY-TX port arbiter: per-port state encoding
// and parameter defaults.
package tx_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int PORTS_DEFAULT        = 4;
    localparam int DWIDTH_DEFAULT       = 8;
    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/tx_port_arb_cell.sv
// One port of the TX arbiter: ownership FSM between SOC (0) and SWITCH (1),
// anti-starvation counter, frame tracking with sticky release errors, write mux.
module tx_port_arb_cell
    import tx_port_arbiter_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic [DWIDTH-1:0] din_0,
    input  logic [DWIDTH-1:0] din_1,
    input  logic              del_0,
    input  logic              del_1,
    input  logic              we_0,
    input  logic              we_1,
    output logic              val_0,
    output logic              val_1,
    output logic              err_0,
    output logic              err_1,
    output logic [DWIDTH-1:0] fifo_din,
    output logic              fifo_we,
    output logic              fifo_del
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_nxt_s;
    logic          open_r;
    logic          open_nxt_s;
    logic          open_after_s;
    logic          err_0_r;
    logic          err_0_nxt_s;
    logic          err_1_r;
    logic          err_1_nxt_s;
    logic          val_0_r;
    logic          val_1_r;
    logic          rdy_r;

    // Next-state, starvation and frame/error bookkeeping for this port.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        open_nxt_s   = open_r;
        open_after_s = open_r;
        err_0_nxt_s  = err_0_r;
        err_1_nxt_s  = err_1_r;
        case (state_r)
            IDLE: begin
                // No grant on the first edge after reset release.
                if (!rdy_r) begin
                    state_nxt_s = IDLE;
                end else if (req_1 && (!req_0 || (starve_r == STARVE_MAX))) begin
                    state_nxt_s  = OWN1;
                    starve_nxt_s = {SW{1'b0}};
                end else if (req_0) begin
                    state_nxt_s = OWN0;
                    if (req_1 && (starve_r != STARVE_MAX)) begin
                        starve_nxt_s = starve_r + SW'(1);
                    end else begin
                        starve_nxt_s = starve_r;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                open_after_s = we_0 ? !del_0 : open_r;
                if (req_0) begin
                    state_nxt_s = OWN0;
                    open_nxt_s  = open_after_s;
                end else begin
                    state_nxt_s = IDLE;
                    open_nxt_s  = 1'b0;
                    err_0_nxt_s = err_0_r | open_after_s;
                end
            end
            OWN1: begin
                open_after_s = we_1 ? !del_1 : open_r;
                if (req_1) begin
                    state_nxt_s = OWN1;
                    open_nxt_s  = open_after_s;
                end else begin
                    state_nxt_s = IDLE;
                    open_nxt_s  = 1'b0;
                    err_1_nxt_s = err_1_r | open_after_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                open_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter, flags and registered grants.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r  <= IDLE;
            starve_r <= {SW{1'b0}};
            open_r   <= 1'b0;
            err_0_r  <= 1'b0;
            err_1_r  <= 1'b0;
            val_0_r  <= 1'b0;
            val_1_r  <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
            open_r   <= open_nxt_s;
            err_0_r  <= err_0_nxt_s;
            err_1_r  <= err_1_nxt_s;
            val_0_r  <= (state_nxt_s == OWN0);
            val_1_r  <= (state_nxt_s == OWN1);
            rdy_r    <= 1'b1;
        end
    end

    // Write mux from the registered owner; non-owner writes never reach the FIFO.
    always_comb begin
        fifo_din = {DWIDTH{1'b0}};
        fifo_we  = 1'b0;
        fifo_del = 1'b0;
        case (state_r)
            OWN0: begin
                fifo_din = din_0;
                fifo_we  = we_0;
                fifo_del = del_0 & we_0;
            end
            OWN1: begin
                fifo_din = din_1;
                fifo_we  = we_1;
                fifo_del = del_1 & we_1;
            end
            default: begin
                fifo_din = {DWIDTH{1'b0}};
                fifo_we  = 1'b0;
                fifo_del = 1'b0;
            end
        endcase
    end

    assign val_0 = val_0_r;
    assign val_1 = val_1_r;
    assign err_0 = err_0_r;
    assign err_1 = err_1_r;

endmodule

// File: rtl/tx_port_arbiter.sv
// Arbitrates SOC and SWITCH access to PORTS PHY-TX FIFOs; each port is an
// independent tx_port_arb_cell.
module tx_port_arbiter
    import tx_port_arbiter_pkg::*;
#(
    parameter int PORTS        = PORTS_DEFAULT,
    parameter int DWIDTH       = DWIDTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [PORTS-1:0]        req_0,
    input  logic [PORTS-1:0]        req_1,
    output logic [PORTS-1:0]        val_0,
    output logic [PORTS-1:0]        val_1,
    input  logic [DWIDTH-1:0]       din_0,
    input  logic [DWIDTH-1:0]       din_1,
    input  logic                    del_0,
    input  logic                    del_1,
    input  logic [PORTS-1:0]        we_0,
    input  logic [PORTS-1:0]        we_1,
    output logic [PORTS*DWIDTH-1:0] fifo_din,
    output logic [PORTS-1:0]        fifo_we,
    output logic [PORTS-1:0]        fifo_del,
    output logic [PORTS-1:0]        err_0,
    output logic [PORTS-1:0]        err_1
);

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        tx_port_arb_cell #(
            .DWIDTH       (DWIDTH),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_cell (
            .clk      (clk),
            .arst_n   (arst_n),
            .req_0    (req_0[p]),
            .req_1    (req_1[p]),
            .din_0    (din_0),
            .din_1    (din_1),
            .del_0    (del_0),
            .del_1    (del_1),
            .we_0     (we_0[p]),
            .we_1     (we_1[p]),
            .val_0    (val_0[p]),
            .val_1    (val_1[p]),
            .err_0    (err_0[p]),
            .err_1    (err_1[p]),
            .fifo_din (fifo_din[p*DWIDTH +: DWIDTH]),
            .fifo_we  (fifo_we[p]),
            .fifo_del (fifo_del[p])
        );
    end

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Directed scenarios plus randomized traffic for tx_port_arbiter, checked
// against a per-port ownership model kept in the bench.
module tb_tx_port_arbiter;

    localparam int P  = 4;
    localparam int D  = 8;
    localparam int SL = 4;

    logic           clk = 1'b0;
    logic           arst_n;
    logic [P-1:0]   req_0, req_1, we_0, we_1;
    logic [P-1:0]   val_0, val_1, fifo_we, fifo_del, err_0, err_1;
    logic [D-1:0]   din_0, din_1;
    logic           del_0, del_1;
    logic [P*D-1:0] fifo_din;

    int n_checks = 0;
    int n_fail   = 0;

    // model: owner 0 = none, 1 = SOC, 2 = SWITCH
    int           owner  [P];
    int           starve [P];
    bit           open_f [P];
    logic [P-1:0] m_err0, m_err1;
    bit           m_rdy;

    tx_port_arbiter #(.PORTS(P), .DWIDTH(D), .STARVE_LIMIT(SL)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .req_0    (req_0),
        .req_1    (req_1),
        .val_0    (val_0),
        .val_1    (val_1),
        .din_0    (din_0),
        .din_1    (din_1),
        .del_0    (del_0),
        .del_1    (del_1),
        .we_0     (we_0),
        .we_1     (we_1),
        .fifo_din (fifo_din),
        .fifo_we  (fifo_we),
        .fifo_del (fifo_del),
        .err_0    (err_0),
        .err_1    (err_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int p = 0; p < P; p++) begin
            owner[p]  = 0;
            starve[p] = 0;
            open_f[p] = 1'b0;
        end
        m_err0 = '0;
        m_err1 = '0;
        m_rdy  = 1'b0;
    endtask

    // Apply the arbitration rules for one rising edge.
    task automatic model_edge();
        int  x;
        bit  w, d, r;
        if (arst_n) begin
            for (int p = 0; p < P; p++) begin
                if (owner[p] == 0) begin
                    if (m_rdy) begin
                        if (req_1[p] && (!req_0[p] || starve[p] >= SL)) begin
                            owner[p]  = 2;
                            starve[p] = 0;
                        end else if (req_0[p]) begin
                            owner[p] = 1;
                            if (req_1[p]) starve[p] = (starve[p] + 1 > SL) ? SL : starve[p] + 1;
                        end
                    end
                end else begin
                    x = owner[p];
                    w = (x == 1) ? we_0[p] : we_1[p];
                    d = (x == 1) ? del_0 : del_1;
                    r = (x == 1) ? req_0[p] : req_1[p];
                    if (w) open_f[p] = !d;
                    if (!r) begin
                        if (open_f[p]) begin
                            if (x == 1) m_err0[p] = 1'b1;
                            else        m_err1[p] = 1'b1;
                        end
                        open_f[p] = 1'b0;
                        owner[p]  = 0;
                    end
                end
            end
            m_rdy = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [P-1:0]   ev0, ev1, ewe, edel;
        logic [P*D-1:0] edin;
        ev0 = '0; ev1 = '0; ewe = '0; edel = '0; edin = '0;
        for (int p = 0; p < P; p++) begin
            if (owner[p] == 1) begin
                ev0[p] = 1'b1;
                ewe[p] = we_0[p];
                edel[p] = we_0[p] & del_0;
                edin[p*D +: D] = din_0;
            end else if (owner[p] == 2) begin
                ev1[p] = 1'b1;
                ewe[p] = we_1[p];
                edel[p] = we_1[p] & del_1;
                edin[p*D +: D] = din_1;
            end
        end
        chk({tag, ".val_0"},    64'(val_0),    64'(ev0));
        chk({tag, ".val_1"},    64'(val_1),    64'(ev1));
        chk({tag, ".err_0"},    64'(err_0),    64'(m_err0));
        chk({tag, ".err_1"},    64'(err_1),    64'(m_err1));
        chk({tag, ".fifo_we"},  64'(fifo_we),  64'(ewe));
        chk({tag, ".fifo_del"}, 64'(fifo_del), 64'(edel));
        chk({tag, ".fifo_din"}, 64'(fifo_din), 64'(edin));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin : stim
        logic [7:0] bytes38 [3];
        logic       dels38  [3];
        bytes38 = '{8'h55, 8'hAA, 8'h0F};
        dels38  = '{1'b0, 1'b0, 1'b1};

        arst_n = 1'b0;
        req_0 = '0; req_1 = '0; we_0 = '0; we_1 = '0;
        din_0 = '0; din_1 = '0; del_0 = 1'b0; del_1 = 1'b0;
        #2;
        reset_model();
        check_all("reset");
        chk("reset_fifo_din", 64'(fifo_din), 64'd0);

        // Both requesters on port 0 straight out of reset.
        #20;
        arst_n = 1'b1;
        req_0[0] = 1'b1;
        req_1[0] = 1'b1;
        tick("s32a");
        chk("s32_first_edge_no_grant", 64'(val_0[0]), 64'd0);
        tick("s36");
        chk("s36_val0", 64'(val_0[0]), 64'd1);
        chk("s36_val1", 64'(val_1[0]), 64'd0);
        req_0[0] = 1'b0; req_1[0] = 1'b0;
        tick("s36_rel");

        // Starvation limit on port 2.
        req_1[2] = 1'b1;
        for (int i = 0; i < SL; i++) begin
            req_0[2] = 1'b1;
            tick("s37_pulse");
            chk("s37_pulse_val0", 64'(val_0[2]), 64'd1);
            req_0[2] = 1'b0;
            tick("s37_gap");
        end
        req_0[2] = 1'b1;
        tick("s37_limit");
        chk("s37_limit_val1", 64'(val_1[2]), 64'd1);
        chk("s37_limit_val0", 64'(val_0[2]), 64'd0);
        req_1[2] = 1'b0;
        tick("s37_drop1");
        chk("s37_idle_val1", 64'(val_1[2]), 64'd0);
        req_1[2] = 1'b1;
        tick("s37_cleared");
        chk("s37_cleared_val0", 64'(val_0[2]), 64'd1);
        req_0[2] = 1'b0; req_1[2] = 1'b0;
        tick("s37_rel");

        // SWITCH frame on port 1, SOC writes to it are ignored.
        req_1[1] = 1'b1;
        tick("s38_grant");
        chk("s38_val1", 64'(val_1[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            din_1 = bytes38[i]; del_1 = dels38[i]; we_1[1] = 1'b1;
            din_0 = 8'h33; del_0 = 1'b1; we_0[1] = 1'b1;
            #1;
            chk("s38_din", 64'(fifo_din[15:8]), 64'(bytes38[i]));
            chk("s38_del", 64'(fifo_del[1]), 64'(dels38[i]));
            tick("s38_wr");
        end
        we_1[1] = 1'b0;
        #1;
        chk("s38_soc_ignored", 64'(fifo_we[1]), 64'd0);
        we_0[1] = 1'b0; del_0 = 1'b0; del_1 = 1'b0; req_1[1] = 1'b0;
        tick("s38_rel");
        chk("s38_no_err", 64'(err_1[1]), 64'd0);

        // SOC abandons an open frame on port 3.
        req_0[3] = 1'b1;
        tick("s39_grant");
        we_0[3] = 1'b1; din_0 = 8'h11;
        tick("s39_b0");
        din_0 = 8'h22;
        tick("s39_b1");
        we_0[3] = 1'b0; req_0[3] = 1'b0;
        tick("s39_rel");
        chk("s39_err", 64'(err_0[3]), 64'd1);
        chk("s39_idle", 64'(val_0[3]), 64'd0);
        tick("s39_sticky");
        chk("s39_err_sticky", 64'(err_0[3]), 64'd1);

        // Concurrent owners on ports 0 and 2; final EOD coincides with release.
        req_0[0] = 1'b1; req_1[2] = 1'b1;
        tick("s40_grant");
        chk("s40_val", 64'({val_1[2], val_0[0]}), 64'd3);
        we_0[0] = 1'b1; we_1[2] = 1'b1; din_0 = 8'hA5; din_1 = 8'h5A;
        #1;
        chk("s40_slice0", 64'(fifo_din[7:0]), 64'hA5);
        chk("s40_slice2", 64'(fifo_din[23:16]), 64'h5A);
        chk("s40_we", 64'(fifo_we), 64'b0101);
        tick("s40_wr");
        del_0 = 1'b1; del_1 = 1'b1; req_0[0] = 1'b0; req_1[2] = 1'b0;
        tick("s40_eod_rel");
        chk("s40_no_err0", 64'(err_0[0]), 64'd0);
        chk("s40_no_err2", 64'(err_1[2]), 64'd0);
        we_0 = '0; we_1 = '0; del_0 = 1'b0; del_1 = 1'b0;

        // Reset in the middle of a SWITCH frame on port 0.
        req_1[0] = 1'b1;
        tick("s41_grant");
        we_1[0] = 1'b1; din_1 = 8'h77;
        tick("s41_wr");
        arst_n = 1'b0;
        #1;
        reset_model();
        chk("s41_async_val1", 64'(val_1), 64'd0);
        chk("s41_async_we", 64'(fifo_we), 64'd0);
        chk("s41_async_err", 64'(err_1), 64'd0);
        check_all("s41_rst");
        tick("s41_held");
        arst_n = 1'b1; we_1[0] = 1'b0;
        tick("s41_e1");
        chk("s41_e1_val1", 64'(val_1[0]), 64'd0);
        tick("s41_e2");
        chk("s41_e2_val1", 64'(val_1[0]), 64'd1);
        req_1[0] = 1'b0;
        tick("s41_rel");

        // Randomized traffic on all ports.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 3) == 0) req_0[p] = ~req_0[p];
                if ($urandom_range(0, 3) == 0) req_1[p] = ~req_1[p];
                we_0[p] = ($urandom_range(0, 1) == 1);
                we_1[p] = ($urandom_range(0, 1) == 1);
            end
            din_0 = 8'($urandom);
            din_1 = 8'($urandom);
            del_0 = ($urandom_range(0, 3) == 0);
            del_1 = ($urandom_range(0, 3) == 0);
            if (c == 200) begin
                arst_n = 1'b0;
                #1;
                reset_model();
                check_all("rnd_rst");
                tick("rnd_rst_hold");
                arst_n = 1'b1;
            end
            #1;
            check_all("rnd_comb");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
